line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Memory-side responder for the cache-to-memory line interface.
- Accepts 256-bit line read and write requests issued by the cache controller on allocate, write-back and flush.
- Services each request from an internal line array after a programmable latency, then pulses mem_ready.
- Sits between the cache controller and main memory; it serves as the main-memory model and as the slot for a later DRAM bridge.

Parameters:
- LATENCY, 4, cycles from request capture to mem_ready pulse; legal values are 1 to 255.
- IDX_W, 10, line-index width; the array holds 2^IDX_W lines of 256 bits.
- CNT_W, 8, latency counter width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  request present.
- mem_rw  in  1  0 = read line, 1 = write line.
- mem_addr  in  28  word address. Bits [2:0] are the word offset (0 for line requests). Bits [IDX_W+2:3] are the line index.
- mem_wr  in  256  write line data.
- mem_rd  out  256  read line data, registered.
- mem_ready  out  1  one-cycle completion pulse, registered.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; counter cleared; capture registers cleared.
  - mem_rd = 0 and mem_ready = 0.
  - Array contents are not reset.
  - Reset mid-request aborts the request: no array write, no mem_ready pulse.
- States:
  - IDLE: if mem_valid = 1 at a rising edge, capture mem_rw, the line index and mem_wr; load counter = LATENCY-1; go to BUSY. Otherwise stay in IDLE.
  - BUSY: counter decrements each cycle. When counter = 0 at an edge:
    - Read: mem_rd <= array[idx].
    - Write: array[idx] <= captured data.
    - In both cases mem_ready <= 1 and the state goes to DONE.
  - DONE: mem_ready <= 0 and the state goes to IDLE.
- Timing:
  - For a request captured at edge E0, mem_ready is high for exactly the cycle between edges E0+LATENCY and E0+LATENCY+1.
  - LATENCY = 1 gives mem_ready in the cycle immediately after capture.
  - Back-to-back request spacing is LATENCY+2 cycles.
- Handshake:
  - Requests are sampled only in IDLE.
  - mem_addr, mem_rw, mem_wr and mem_valid changes during BUSY/DONE are ignored; the captured request completes even if mem_valid drops.
  - If mem_valid is still high in IDLE after DONE, it is a new request. Flush streams therefore hold mem_valid high and change mem_addr after each mem_ready.
- mem_rd:
  - Updates only on read completion and otherwise holds its value.
  - Write completions do not change mem_rd.
- Address handling:
  - Bits [27:IDX_W+3] are ignored, so addresses alias modulo 2^IDX_W lines.
  - Bits [2:0] are ignored.
- Read-after-write to the same line as consecutive requests returns the new data; there is no hazard because the write commits before DONE.
- The array is a single-port, synchronous-write, registered-read structure and is inferable as block RAM.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - Adds output mem_err (1 bit, reset 0), which pulses in the same cycle as mem_ready.
  - The pulse fires for a request captured with addr[2:0] != 0 or any addr[27:IDX_W+3] != 0.
  - An erroring write does not modify the array.
  - An erroring read returns mem_rd = 0.
  - Timing is unchanged.
- Undefined:
  - No mem_err port.
  - Out-of-range addresses alias and misaligned offsets are ignored, as described above.

Test Plan:
- Write then read, LATENCY=4:
  - Write addr 28'h0000_A08 with data {8{32'hDEAD_BEEF}}; mem_ready pulses 4 cycles after capture.
  - Then read the same address; mem_rd = {8{32'hDEAD_BEEF}} in the mem_ready cycle and holds afterwards.
- Latency sweep:
  - With LATENCY=1 and with LATENCY=7, measure capture-to-mem_ready distance; it must be 1 and 7 cycles respectively.
  - mem_ready must be exactly 1 cycle wide.
- Flush stream:
  - Hold mem_valid=1, mem_rw=1 and advance addr by 8 on each mem_ready for 1024 lines with data = line index.
  - Read back lines 0, 511 and 1023; they must return 0, 511 and 1023.
- Ignore changes and aliasing:
  - Capture a read of line 3, then change addr and drop mem_valid during BUSY; mem_rd must still equal array[3].
  - A read at addr 28'h0002_018 (IDX_W=10) must return the line-3 contents.
- Reset mid-request:
  - Assert rst 2 cycles after capturing a write of 256'h1 to line 5; no mem_ready pulse occurs.
  - A subsequent read of line 5 must return its previous value.
- With MEM_ADDR_CHECK_EN:
  - Write to addr 28'h0000_009 with data 256'hF; mem_err and mem_ready pulse together.
  - A read of line 1 must return its prior data.
  - A read of addr 28'h0100_000 must return mem_rd = 0 with mem_err = 1.

Source files
------------

// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side responder for the cache line interface.
// Captures one 256-bit line read/write request, waits LATENCY cycles, then
// services it from an internal line array and pulses mem_ready.
// Optional feature macro: MEM_ADDR_CHECK_EN adds mem_err for misaligned or
// out-of-range addresses; erroring writes are dropped and erroring reads
// return zero.
//
// state | meaning
// IDLE  | waiting for mem_valid; request sampled here only
// BUSY  | latency countdown; array access at terminal count
// DONE  | mem_ready high for this cycle; returns to IDLE

module line_mem_responder #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 10,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_valid,
    input  logic         mem_rw,
    input  logic [27:0]  mem_addr,
    input  logic [255:0] mem_wr,
    output logic [255:0] mem_rd,
`ifdef MEM_ADDR_CHECK_EN
    output logic         mem_err,
`endif
    output logic         mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw;
    logic [IDX_W-1:0]   r_idx;
    logic [255:0]       r_data;
    logic               r_err;
    logic               r_err_out;

    logic [255:0]       r_mem [2**IDX_W];

    logic [IDX_W-1:0]   w_idx;
    logic               w_addr_err;
    logic               w_done_now;
    logic               w_wr_en;

    assign w_idx      = mem_addr[IDX_W+2:3];
    assign w_done_now = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_wr_en    = w_done_now && r_rw && !r_err;

`ifdef MEM_ADDR_CHECK_EN
    // Any nonzero word offset or any bit above the line index is an error.
    assign w_addr_err = (mem_addr[2:0] != 3'd0) || (mem_addr[27:IDX_W+3] != '0);
    assign mem_err    = r_err_out;
`else
    // Offset and high bits are don't-care: addresses alias across the array.
    logic w_unused_addr;
    assign w_unused_addr = ^{mem_addr[27:IDX_W+3], mem_addr[2:0], r_err_out};
    assign w_addr_err    = 1'b0;
`endif

    // Line array write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_idx] <= r_data;
        end
    end

    // Request FSM: capture in IDLE, count down in BUSY, pulse completion in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rw      <= 1'b0;
            r_idx     <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_err_out <= 1'b0;
            mem_rd    <= '0;
            mem_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    mem_ready <= 1'b0;
                    r_err_out <= 1'b0;
                    if (mem_valid) begin
                        r_rw    <= mem_rw;
                        r_idx   <= w_idx;
                        r_data  <= mem_wr;
                        r_err   <= w_addr_err;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (!r_rw) begin
                            mem_rd <= r_err ? '0 : r_mem[r_idx];
                        end
                        mem_ready <= 1'b1;
                        r_err_out <= r_err;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    mem_ready <= 1'b0;
                    r_err_out <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    r_err_out <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder (LATENCY=4 main instance plus
// LATENCY=1 and LATENCY=7 instances for the latency sweep).
// Build with +define+MEM_ADDR_CHECK_EN to exercise the address-check feature.

module tb_line_mem_responder;

    logic         clk;
    logic         rst;
    logic         valid;
    logic         v1;
    logic         v7;
    logic         rw;
    logic [27:0]  addr;
    logic [255:0] wr;
    logic [255:0] rd4, rd1, rd7;
    logic         ready4, ready1, ready7;
`ifdef MEM_ADDR_CHECK_EN
    logic         err4, err1, err7;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [255:0] rd;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    exp_t         e_mon;
    logic [255:0] mdl [1024];
    logic [255:0] last_rd = '0;

    line_mem_responder #(.LATENCY(4), .IDX_W(10), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .mem_valid(valid), .mem_rw(rw),
        .mem_addr(addr), .mem_wr(wr), .mem_rd(rd4),
`ifdef MEM_ADDR_CHECK_EN
        .mem_err(err4),
`endif
        .mem_ready(ready4));

    line_mem_responder #(.LATENCY(1), .IDX_W(10), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .mem_valid(v1), .mem_rw(rw),
        .mem_addr(addr), .mem_wr(wr), .mem_rd(rd1),
`ifdef MEM_ADDR_CHECK_EN
        .mem_err(err1),
`endif
        .mem_ready(ready1));

    line_mem_responder #(.LATENCY(7), .IDX_W(10), .CNT_W(8)) dut7 (
        .clk(clk), .rst(rst), .mem_valid(v7), .mem_rw(rw),
        .mem_addr(addr), .mem_wr(wr), .mem_rd(rd7),
`ifdef MEM_ADDR_CHECK_EN
        .mem_err(err7),
`endif
        .mem_ready(ready7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference model: update on push, record what the completion must show.
    task automatic sb_push(input logic r_w, input logic [27:0] a, input logic [255:0] d);
        exp_t e;
        logic err;
        int   idx;
        idx = int'(a[12:3]);
`ifdef MEM_ADDR_CHECK_EN
        err = (a[2:0] != 3'd0) || (a[27:13] != 15'd0);
`else
        err = 1'b0;
`endif
        if (r_w) begin
            if (!err) mdl[idx] = d;
            e.rd = last_rd;
        end else begin
            e.rd    = err ? 256'd0 : mdl[idx];
            last_rd = e.rd;
        end
        e.err = err;
        sb.push_back(e);
    endtask

    // Completion monitor for the main instance, pops the scoreboard.
    always @(negedge clk) begin
        if (!rst && ready4) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 256'd1, 256'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("rd", rd4, e_mon.rd);
`ifdef MEM_ADDR_CHECK_EN
                chk("err", {255'd0, err4}, {255'd0, e_mon.err});
`endif
            end
        end
    end

    task automatic do_req(input logic r_w, input logic [27:0] a, input logic [255:0] d);
        int n;
        @(negedge clk);
        valid = 1'b1; rw = r_w; addr = a; wr = d;
        sb_push(r_w, a, d);
        @(posedge clk); #1;
        valid = 1'b0; addr = 28'($urandom); wr = {8{$urandom()}}; rw = ~r_w;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready4 && n < 300);
        chk("lat", 256'(n), 256'd4);
        @(posedge clk); #1;
        chk("width", {255'd0, ready4}, 256'd0);
    endtask

    function automatic logic rdy(input int which);
        return (which == 1) ? ready1 : ready7;
    endfunction

    task automatic lat_test(input int which, input int lat);
        int n;
        @(negedge clk);
        rw = 1'b0; addr = 28'd0;
        if (which == 1) v1 = 1'b1; else v7 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; v7 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!rdy(which) && n < 300);
        chk("lat_sweep", 256'(n), 256'(lat));
        @(posedge clk); #1;
        chk("width_sweep", {255'd0, rdy(which)}, 256'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nrdy;
        rst = 1'b1; valid = 1'b0; v1 = 1'b0; v7 = 1'b0;
        rw = 1'b0; addr = '0; wr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {255'd0, ready4}, 256'd0);
        chk("rst_rd", rd4, 256'd0);
        @(negedge clk); rst = 1'b0;

        // Write then read one line, mem_rd holds afterwards.
        do_req(1'b1, 28'h0000_A08, {8{32'hDEAD_BEEF}});
        do_req(1'b0, 28'h0000_A08, 256'd0);
        repeat (3) @(posedge clk);
        #1 chk("rd_hold", rd4, {8{32'hDEAD_BEEF}});

        lat_test(1, 1);
        lat_test(7, 7);

        // Flush stream: valid held high, address advanced on each mem_ready.
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 28'd0; wr = 256'd0;
        sb_push(1'b1, 28'd0, 256'd0);
        for (int i = 0; i < 1024; i++) begin
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (!ready4 && n < 300);
            if (!ready4) begin
                chk("flush_timeout", 256'(i), 256'd1024);
                break;
            end
            if (i < 1023) begin
                addr = 28'((i + 1) * 8);
                wr   = 256'(i + 1);
                sb_push(1'b1, addr, wr);
            end else begin
                valid = 1'b0;
            end
        end
        @(posedge clk); #1;

        do_req(1'b0, 28'd0, 256'd0);
        do_req(1'b0, 28'(511 * 8), 256'd0);
        do_req(1'b0, 28'(1023 * 8), 256'd0);
        do_req(1'b0, 28'(3 * 8), 256'd0);
        do_req(1'b0, 28'h0002_018, 256'd0);

        // Reset two cycles after capturing a write to line 5.
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 28'(5 * 8); wr = 256'h1;
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        nrdy = 0;
        @(negedge clk) rst = 1'b0;
        last_rd = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ready4) nrdy++;
        end
        chk("rst_abort", 256'(nrdy), 256'd0);
        chk("rst_rd_clr", rd4, 256'd0);
        do_req(1'b0, 28'(5 * 8), 256'd0);

`ifdef MEM_ADDR_CHECK_EN
        do_req(1'b1, 28'h0000_009, 256'hF);
        do_req(1'b0, 28'h0000_008, 256'd0);
        do_req(1'b0, 28'h0100_000, 256'd0);
`endif

        repeat (2) @(posedge clk);
        #1 chk("sb_drain", 256'(sb.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
